// File: rtl/ponto_fixo_pkg.sv
// Shared definitions for the fixed-point ALU: op encoding, FSM states, saturation fill.
package ponto_fixo_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Fill bit of the clamped result: subtract clamps to zero, everything else to all-ones.
  function automatic logic sat_fill(input logic [1:0] op);
    return (op != OP_SUB);
  endfunction

endpackage

// File: rtl/ponto_fixo_mul_seq.sv
// Shift-add multiplier: one bit of b per cycle, WIDTH cycles per product, no early exit.
module ponto_fixo_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] partial;

  // p already includes this cycle's partial product so the caller can capture it on the
  // same edge that processes the last bit.
  always_comb begin
    partial = b_q[cnt_q] ? (a_q << cnt_q) : '0;
    p       = acc_q + partial;
    done    = busy_q && (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= {{WIDTH{1'b0}}, a};
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= p;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ponto_fixo_alu_seq.sv
// Unsigned Q(WIDTH-FRAC).FRAC add/sub/mul/pass unit with valid/ready on both sides.
// Define PONTO_FIXO_SAT_EN to clamp overflowing results instead of wrapping.
module ponto_fixo_alu_seq
  import ponto_fixo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  state_e             state_q;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_ovf;
  logic [WIDTH-1:0]   imm_out;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_out;

  // Gated by rst_n so the source sees not-ready while reset is held.
  assign in_ready  = rst_n && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  ponto_fixo_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    imm_res = a;
    imm_ovf = 1'b0;
    case (op)
      OP_ADD:  begin imm_res = sum[WIDTH-1:0];  imm_ovf = sum[WIDTH];  end
      OP_SUB:  begin imm_res = diff[WIDTH-1:0]; imm_ovf = diff[WIDTH]; end
      default: begin imm_res = a;               imm_ovf = 1'b0;        end
    endcase
    mul_res = mul_p[WIDTH+FRAC-1:FRAC];
    mul_ovf = |mul_p[2*WIDTH-1:WIDTH+FRAC];
`ifdef PONTO_FIXO_SAT_EN
    imm_out = imm_ovf ? {WIDTH{sat_fill(op)}} : imm_res;
    mul_out = mul_ovf ? {WIDTH{sat_fill(OP_MUL)}} : mul_res;
`else
    imm_out = imm_res;
    mul_out = mul_res;
`endif
  end

  // Fraction bits below the result window are truncated away.
  generate
    if (FRAC > 0) begin : g_trunc
      logic unused_frac;
      assign unused_frac = ^mul_p[FRAC-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q <= StMul;
            end else begin
              result   <= imm_out;
              overflow <= imm_ovf;
              state_q  <= StDone;
            end
          end
        end
        StMul: begin
          if (mul_done) begin
            result   <= mul_out;
            overflow <= mul_ovf;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ponto_fixo_alu_seq.sv
// Self-checking bench for ponto_fixo_alu_seq: directed cases then random ops vs. arithmetic model.
module tb_ponto_fixo_alu_seq;

  localparam int unsigned W    = 8;
  localparam int unsigned FRAC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ponto_fixo_alu_seq #(
    .WIDTH (W),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic straight from the Q-format rules.
  task automatic model(input int o, input longint unsigned x, input longint unsigned y,
                       output longint unsigned r, output bit v);
    longint unsigned mask;
    longint unsigned full;
    mask = (64'd1 << W) - 1;
    case (o)
      0: begin full = x + y; r = full & mask; v = (full > mask); end
      1: begin r = (x - y) & mask; v = (x < y); end
      2: begin full = x * y; r = (full >> FRAC) & mask; v = ((full >> (W + FRAC)) != 0); end
      default: begin r = x; v = 1'b0; end
    endcase
`ifdef PONTO_FIXO_SAT_EN
    if (v) r = (o == 1) ? 64'd0 : mask;
`endif
  endtask

  // Called one step after a rising edge with the DUT idle; returns likewise.
  task automatic run_op(input int o, input int unsigned x, input int unsigned y, input int hold);
    longint unsigned exp_r;
    bit exp_v;
    int n;
    int exp_lat;
    model(o, x, y, exp_r, exp_v);
    exp_lat = (o == 2) ? W + 1 : 1;
    op = 2'(o); a = W'(x); b = W'(y);
    in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      // Junk on the input side while busy must be ignored.
      op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      if (!out_valid) check("in_ready_busy", 64'(in_ready), 64'd0);
    end while (!out_valid && n < 40);
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(exp_lat));
    check("result", 64'(result), exp_r);
    check("overflow", 64'(overflow), 64'(exp_v));
    check("in_ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), exp_r);
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);

    run_op(0, 'h18, 'h28, 0);
    run_op(0, 'hF0, 'h20, 0);
    run_op(1, 'h10, 'h20, 0);
    run_op(1, 'h30, 'h10, 1);
    run_op(2, 'h18, 'h28, 0);
    run_op(2, 'h80, 'h40, 5);
    run_op(2, 'h00, 'hFF, 0);
    run_op(2, 'hFF, 'h00, 0);
    run_op(2, 'hFF, 'hFF, 0);
    run_op(3, 'hA5, 'h3C, 2);

    // Reset in the middle of a multiply: outputs clear at once, nothing emerges afterwards.
    op = 2'b10; a = 8'h18; b = 8'h28; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      check("no_spurious_valid", 64'(out_valid), 64'd0);
      check("idle_ready", 64'(in_ready), 64'd1);
    end
    out_ready = 1'b0;
    run_op(0, 'h18, 'h28, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 3)), $urandom_range(0, 255), $urandom_range(0, 255),
             int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ponto_fixo_alu_seq.md
Name: ponto_fixo_alu_seq

Overview:
- Parametrised unsigned fixed-point arithmetic unit in Q(WIDTH-FRAC).FRAC format, supporting add, subtract and multiply.
- Add/sub complete in one cycle. Multiply uses a sequential shift-add engine taking WIDTH iterations.
- A valid/ready handshake on both sides lets it sit between an operand source and a result sink in the datapath.
- Successor to the 8-bit Q4.4 combinational add/sub: generalised width and fraction, adds multiply, registered outputs and flow control.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is WIDTH >= 2.
- FRAC, 4, number of fraction bits. Legal range is 0 <= FRAC < WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept a new operation.
- op  in  2  operation select: 00 add, 01 sub, 10 mul, 11 pass-through a.
- a  in  WIDTH  operand A, unsigned Q format.
- b  in  WIDTH  operand B, unsigned Q format.
- out_valid  out  1  result is valid.
- out_ready  in  1  sink accepts the result.
- result  out  WIDTH  registered result.
- overflow  out  1  registered overflow/borrow flag for the result.

Behaviour:
- Reset: clk and rst_n are fixed as stated; reset is asynchronous and active-low.
  - While rst_n is low, the FSM returns to IDLE regardless of state.
  - result, overflow and out_valid clear to 0; in_ready reads 0 during reset and 1 afterwards.
  - Iteration counter and partial product clear; an in-flight multiply is discarded with no output.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- Accept: occurs on an edge where in_valid && in_ready.
  - op 00/01/11: result and overflow are computed and registered on the accept edge; next state DONE. Latency is 1 cycle.
  - op 10: a and b are latched; 2*WIDTH accumulator and counter are zeroed; next state MUL.
- MUL state:
  - Each edge examines bit cnt of latched b; if set, adds (a << cnt) to the accumulator; cnt increments.
  - On the edge processing cnt == WIDTH-1, result and overflow are loaded and the state moves to DONE.
  - out_valid is visible WIDTH+1 edges after the accept.
- DONE state:
  - result and overflow are held stable while out_ready is low.
  - The state moves to IDLE on an edge with out_ready high.
  - No new accept occurs in the same edge, so add throughput is one result per 2 cycles.
- Arithmetic rules:
  - Add: {carry, sum} = a + b in WIDTH+1 bits; result = sum; overflow = carry.
  - Sub: a - b in WIDTH+1 bits; result = low WIDTH bits; overflow = borrow (a < b).
  - Mul: P = a*b in 2*WIDTH bits; result = P[WIDTH+FRAC-1:FRAC] (truncation toward zero); overflow = |P[2*WIDTH-1:WIDTH+FRAC]. When FRAC == 0 the upper slice is P[2W-1:W].
  - Pass-through (op 11): result = a; overflow = 0.
- Boundary cases:
  - in_valid high while not in IDLE is ignored; the source must hold its operands until accepted.
  - op, a and b changes during MUL have no effect.
  - a = 0 or b = 0 under mul gives result 0, overflow 0, at full WIDTH+1 latency; there is no early exit.
  - Wrap-around without saturation is modulo 2^WIDTH.

Optional Feature:
- Macro: PONTO_FIXO_SAT_EN.
- Defined: on overflow, result saturates instead of wrapping.
  - Add and mul clamp to all-ones (max representable value).
  - Sub clamps to zero.
  - The overflow flag is still reported.
- Undefined: results wrap as stated above; no saturation logic is synthesised.

Decomposition:
- Shared package ponto_fixo_pkg holds:
  - op encoding localparams OP_ADD, OP_SUB, OP_MUL, OP_PASS.
  - FSM state typedef (IDLE/MUL/DONE).
  - a function computing the saturation value per op.
- One natural sub-module, ponto_fixo_mul_seq: the shift-add engine.
  - Inputs: start, a, b.
  - Outputs: done, P[2*WIDTH-1:0].
  - Owns the counter and accumulator.
- The top module owns the handshake FSM, add/sub path, result slicing and the saturation mux.

Test Plan:
- WIDTH=8, FRAC=4, add 0x18+0x28 (1.5+2.5) -> result 0x40, overflow 0; out_valid one cycle after accept.
- Add 0xF0+0x20 -> result 0x10, overflow 1; with PONTO_FIXO_SAT_EN -> result 0xFF, overflow 1.
- Sub 0x10-0x20 -> result 0xF0, overflow 1 (SAT: 0x00); sub 0x30-0x10 -> 0x20, overflow 0.
- Mul 0x18*0x28 (1.5*2.5) -> result 0x3C (3.75), overflow 0; out_valid exactly 9 edges after accept; in_ready low throughout.
- Mul 0x80*0x40 (8*4) -> result 0x00, overflow 1 (SAT: 0xFF). Hold out_ready low 5 cycles -> result stable, out_valid high, in_ready low; then IDLE one edge after out_ready rises.
- Assert rst_n low at MUL iteration 4 -> outputs 0 immediately (asynchronous). After release, IDLE with in_ready 1 and no spurious out_valid; a fresh add completes correctly.
